apb2wb_sync_bridge: RTL

Registered, parametrised APB-to-Wishbone bridge: a single-clock APB completer that converts each APB access into one Wishbone classic cycle. Unlike a combinational pass-through bridge, it registers every Wishbone output, buffers read data, inserts APB wait states until the Wishbone slave terminates, and reports slave errors or timeouts on PSLVERR. It sits between the APB interconnect and any Wishbone peripheral on the same clock.

---
 rtl/apb2wb_pkg.sv | 30 +++
 rtl/apb2wb_lane_swap.sv | 32 +++
 rtl/apb2wb_sync_bridge.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/apb2wb_pkg.sv
// ============================================================================
// Module : apb2wb_pkg
// Brief  : Shared types and constant helpers for the APB-to-Wishbone bridge.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package apb2wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned c_LANE_W = 8;

    function automatic int unsigned lanes(input int unsigned data_width);
        return data_width / c_LANE_W;
    endfunction

    // A zero timeout still needs a one-bit counter to keep the datapath legal.
    function automatic int unsigned tmo_cnt_w(input int unsigned timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb2wb_lane_swap.sv
// ============================================================================
// Module : apb2wb_lane_swap
// Brief  : Combinational lane reorder; reverses lanes when APB2WB_ENDIAN_SWAP_EN
//          is defined, otherwise a straight pass-through.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module apb2wb_lane_swap
    import apb2wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = c_LANE_W
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int c_LANES = DATA_WIDTH / LANE_W;

    for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
`ifdef APB2WB_ENDIAN_SWAP_EN
        assign o_data[gi*LANE_W +: LANE_W] = i_data[(c_LANES-1-gi)*LANE_W +: LANE_W];
`else
        assign o_data[gi*LANE_W +: LANE_W] = i_data[gi*LANE_W +: LANE_W];
`endif
    end

endmodule

`default_nettype wire

// File: rtl/apb2wb_sync_bridge.sv
// ============================================================================
// Module : apb2wb_sync_bridge
// Brief  : Registered APB completer issuing one Wishbone classic cycle per
//          access, with wait states, error/timeout reporting and optional
//          byte-lane swap (APB2WB_ENDIAN_SWAP_EN).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module apb2wb_sync_bridge
    import apb2wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic                      PREADY,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PSLVERR,
    output logic                      cyc,
    output logic                      stb,
    output logic                      we,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic [DATA_WIDTH/8-1:0]   sel,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      ack,
    input  logic                      err
);

    localparam int c_LANES = lanes(DATA_WIDTH);
    localparam int c_CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  r_state, w_next;
    logic [c_CNT_W-1:0]      r_tmo, w_tmo;
    logic                    r_cyc, w_cyc;
    logic                    r_we, w_we;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata;
    logic [c_LANES-1:0]      r_sel, w_sel;
    logic                    r_pready, w_pready;
    logic                    r_pslverr, w_pslverr;
    logic [DATA_WIDTH-1:0]   r_prdata, w_prdata;

    logic [DATA_WIDTH-1:0]   w_wdata_sw;
    logic [DATA_WIDTH-1:0]   w_rdata_sw;
    logic [c_LANES-1:0]      w_strb_sw;
    logic                    w_start;
    logic                    w_tmo_hit;
    logic                    w_done;

    apb2wb_lane_swap #(.DATA_WIDTH(DATA_WIDTH), .LANE_W(8)) u_swap_wdata (
        .i_data (PWDATA),
        .o_data (w_wdata_sw)
    );

    apb2wb_lane_swap #(.DATA_WIDTH(c_LANES), .LANE_W(1)) u_swap_sel (
        .i_data (PSTRB),
        .o_data (w_strb_sw)
    );

    apb2wb_lane_swap #(.DATA_WIDTH(DATA_WIDTH), .LANE_W(8)) u_swap_rdata (
        .i_data (data_i),
        .o_data (w_rdata_sw)
    );

    assign w_start   = PSEL & PENABLE;
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo == c_TMO_LAST);
    assign w_done    = err | ack | w_tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = WB;
            WB:      if (w_done)  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next values for every registered output; PSEL is ignored once in WB.
    always_comb begin
        w_cyc     = 1'b0;
        w_we      = r_we;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_sel     = r_sel;
        w_tmo     = r_tmo;
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_cyc   = 1'b1;
                    w_we    = PWRITE;
                    w_addr  = PADDR;
                    w_wdata = w_wdata_sw;
                    w_sel   = PWRITE ? w_strb_sw : '1;
                    w_tmo   = '0;
                end
            end
            WB: begin
                w_tmo = r_tmo + 1'b1;
                if (w_done) begin
                    w_pready  = 1'b1;
                    w_pslverr = err | ~ack;
                    w_prdata  = (!err && ack && !r_we) ? w_rdata_sw : '0;
                end else begin
                    w_cyc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo     <= '0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_tmo     <= w_tmo;
            r_cyc     <= w_cyc;
            r_we      <= w_we;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_sel     <= w_sel;
            r_pready  <= w_pready;
            r_pslverr <= w_pslverr;
            r_prdata  <= w_prdata;
        end
    end

    assign cyc     = r_cyc;
    assign stb     = r_cyc;
    assign we      = r_we;
    assign addr    = r_addr;
    assign data_o  = r_wdata;
    assign sel     = r_sel;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
    assign PRDATA  = r_prdata;

endmodule

`default_nettype wire
